// File: rtl/uart_dram_loader_pkg.sv
// Shared definitions for the UART-to-DRAM image loader.
//  - default parameter values (UART bit period, image size, RAM address width)
//  - loader and RX sampler state encodings
package uart_dram_loader_pkg;

  localparam int UART_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
  localparam int IMG_BYTES_DEFAULT = 65536;
  localparam int ADDR_W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_WRITE,
    LD_DONE
  } loader_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_dram_loader_if.sv
// RAM write-port bundle between the loader and the data RAM.
//  dram_addr  : write address
//  dram_din   : write data byte
//  dram_write : 1-cycle write strobe, addr/din valid in the same cycle
// The loader drives the bus (master); the RAM consumes it (slave).
interface uart_dram_loader_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] dram_addr;
  logic [7:0]        dram_din;
  logic              dram_write;

  modport master (output dram_addr, output dram_din, output dram_write);
  modport slave  (input  dram_addr, input  dram_din, input  dram_write);

endinterface

// File: rtl/uart_dram_loader_uart_rx.sv
// UART receiver (8N1, LSB first) with a 2-FF input synchronizer.
//  clk, rst_n     : system clock, async active-low reset
//  i_rx           : raw serial line, idle high, asynchronous to clk
//  o_byte_valid   : 1-cycle pulse, a byte with a good stop bit is in o_byte_data
//  o_byte_data    : last received byte
//  o_stop_err     : 1-cycle pulse, the stop bit was sampled low (byte discarded)
// The sampler runs continuously; after every frame it waits for the line to
// be high again before it looks for the next start edge.
module uart_rx
  import uart_dram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_stop_err
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_stop_err;
  logic             w_fall;

  // NOTE: the synchronizer resets to 1 (line idle) so that releasing reset
  // never looks like a start-bit falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        // Check the start bit half a bit period after the edge; a high line
        // there means a glitch, not a frame.
        RX_START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == LP_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};   // LSB arrives first
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == LP_FULL) begin
            r_cnt <= '0;
            if (r_rx_sync) r_byte_valid <= 1'b1;
            else           r_stop_err   <= 1'b1;
            r_state <= RX_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_sync) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_stop_err   = r_stop_err;

endmodule

// File: rtl/uart_dram_loader.sv
// UART image loader: receives IMG_BYTES bytes over UART and writes them to
// sequential RAM addresses starting at 0, then raises load_done.
//  clk, rst_n  : system clock, async active-low reset
//  start       : 1-cycle pulse, arms a new load (ignored while busy)
//  rx          : UART serial input
//  dram        : RAM write port (addr / din / 1-cycle write strobe)
//  busy        : load in progress (LOAD or WRITE)
//  load_done   : level, all bytes of the current load are written
//  frame_err   : sticky, a byte with a low stop bit was seen during this load
//  byte_count  : bytes written in the current load (ADDR_W+1 bits)
module uart_dram_loader
  import uart_dram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int IMG_BYTES    = IMG_BYTES_DEFAULT,
  parameter int ADDR_W       = ADDR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 rx,
  uart_dram_loader_if.master   dram,
  output logic                 busy,
  output logic                 load_done,
  output logic                 frame_err,
  output logic [ADDR_W:0]      byte_count
);

  localparam logic [ADDR_W:0] LP_IMG_BYTES = (ADDR_W + 1)'(IMG_BYTES);

  logic          w_byte_valid;
  logic [7:0]    w_byte_data;
  logic          w_stop_err;
  logic [ADDR_W:0] w_count_next;

  loader_state_e   r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]      r_din;
  logic            r_write;
  logic            r_busy;
  logic            r_load_done;
  logic            r_frame_err;
  logic [ADDR_W:0] r_byte_count;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_stop_err   (w_stop_err)
  );

  assign w_count_next = r_byte_count + 1'b1;

  // Bytes and stop errors arriving in IDLE/DONE fall through untouched, which
  // is how they get dropped. The address simply rolls over on the final byte
  // when IMG_BYTES == 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LD_IDLE;
      r_addr       <= '0;
      r_din        <= '0;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            r_state      <= LD_LOAD;
            r_addr       <= '0;
            r_byte_count <= '0;
            r_frame_err  <= 1'b0;
            r_load_done  <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (w_stop_err) r_frame_err <= 1'b1;
          if (w_byte_valid) begin
            r_write <= 1'b1;
            r_din   <= w_byte_data;
            r_state <= LD_WRITE;
          end
        end
        // The strobe is high during this state; advance address and count
        // for the next byte.
        LD_WRITE: begin
          if (w_stop_err) r_frame_err <= 1'b1;
          r_addr       <= r_addr + 1'b1;
          r_byte_count <= w_count_next;
          if (w_count_next == LP_IMG_BYTES) begin
            r_state     <= LD_DONE;
            r_load_done <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state <= LD_LOAD;
          end
        end
        default: r_state <= LD_IDLE;
      endcase
    end
  end

  assign dram.dram_addr  = r_addr;
  assign dram.dram_din   = r_din;
  assign dram.dram_write = r_write;
  assign busy            = r_busy;
  assign load_done       = r_load_done;
  assign frame_err       = r_frame_err;
  assign byte_count      = r_byte_count;

endmodule

// File: tb/tb_uart_dram_loader.sv
// Bench for uart_dram_loader. Two instances:
//  dut_a : CLKS_PER_BIT=4, IMG_BYTES=4,  ADDR_W=16
//  dut_b : CLKS_PER_BIT=4, IMG_BYTES=16, ADDR_W=4 (full address space, wrap)
// Expected RAM writes are queued as stimulus is issued; monitors pop and
// compare on every write strobe.
module tb_uart_dram_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, rx_a, rx_b;
  logic        busy_a, load_done_a, frame_err_a;
  logic [16:0] byte_count_a;
  logic        busy_b, load_done_b, frame_err_b;
  logic [4:0]  byte_count_b;

  uart_dram_loader_if #(.ADDR_W(16)) bus_a ();
  uart_dram_loader_if #(.ADDR_W(4))  bus_b ();

  uart_dram_loader #(.CLKS_PER_BIT(CPB), .IMG_BYTES(4), .ADDR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rx(rx_a), .dram(bus_a),
    .busy(busy_a), .load_done(load_done_a), .frame_err(frame_err_a),
    .byte_count(byte_count_a)
  );

  uart_dram_loader #(.CLKS_PER_BIT(CPB), .IMG_BYTES(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rx(rx_b), .dram(bus_b),
    .busy(busy_b), .load_done(load_done_b), .frame_err(frame_err_b),
    .byte_count(byte_count_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] q_a[$];
  logic [11:0] q_b[$];
  logic [23:0] exp_a;
  logic [11:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (bus_a.dram_write === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_a_unexpected: addr=0x%0h data=0x%0h, no write expected",
                 bus_a.dram_addr, bus_a.dram_din);
      end else begin
        exp_a = q_a.pop_front();
        check("write_a {addr,data}", 32'({bus_a.dram_addr, bus_a.dram_din}), 32'(exp_a));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.dram_write === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_b_unexpected: addr=0x%0h data=0x%0h, no write expected",
                 bus_b.dram_addr, bus_b.dram_din);
      end else begin
        exp_b = q_b.pop_front();
        check("write_b {addr,data}", 32'({bus_b.dram_addr, bus_b.dram_din}), 32'(exp_b));
      end
    end
  end

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // One 8N1 frame, then 8 idle bit-clocks so the write has completed on return.
  task automatic send_byte(input bit sel, input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, frame[i]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(sel, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    int n;
    n = 0;
    while (!(sel ? load_done_b : load_done_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sel ? load_done_b : load_done_a), 32'd1);
  endtask

  task automatic load_a(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] d[4];
    d = '{b0, b1, b2, b3};
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      q_a.push_back({16'(i), d[i]});
      send_byte(1'b0, d[i], 1'b1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy_a",       32'(busy_a), 0);
    check("rst load_done_a",  32'(load_done_a), 0);
    check("rst frame_err_a",  32'(frame_err_a), 0);
    check("rst byte_count_a", 32'(byte_count_a), 0);
    check("rst dram_write_a", 32'(bus_a.dram_write), 0);
    check("rst dram_addr_a",  32'(bus_a.dram_addr), 0);
    check("rst load_done_b",  32'(load_done_b), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    @(negedge clk);

    // 1: basic load of four bytes
    do_reset();
    load_a(8'hA5, 8'h3C, 8'hFF, 8'h00);
    wait_done(1'b0, "t1 load_done");
    check("t1 byte_count", 32'(byte_count_a), 4);
    check("t1 frame_err",  32'(frame_err_a), 0);
    check("t1 busy",       32'(busy_a), 0);
    check("t1 dram_addr",  32'(bus_a.dram_addr), 4);

    // 2: a byte before start is dropped
    do_reset();
    send_byte(1'b0, 8'h11, 1'b1);
    check("t2 count before start", 32'(byte_count_a), 0);
    check("t2 busy before start",  32'(busy_a), 0);
    load_a(8'h01, 8'h02, 8'h80, 8'h7E);
    wait_done(1'b0, "t2 load_done");
    check("t2 byte_count", 32'(byte_count_a), 4);

    // 3: bad stop bit on 2nd byte -> not written, load continues
    pulse_start(1'b0);
    check("t3 load_done cleared", 32'(load_done_a), 0);
    check("t3 busy on start",     32'(busy_a), 1);
    q_a.push_back({16'd0, 8'h5A});
    send_byte(1'b0, 8'h5A, 1'b1);
    check("t3 frame_err before", 32'(frame_err_a), 0);
    send_byte(1'b0, 8'hC3, 1'b0);
    check("t3 frame_err set",    32'(frame_err_a), 1);
    check("t3 count after bad",  32'(byte_count_a), 1);
    q_a.push_back({16'd1, 8'h96}); send_byte(1'b0, 8'h96, 1'b1);
    q_a.push_back({16'd2, 8'h69}); send_byte(1'b0, 8'h69, 1'b1);
    q_a.push_back({16'd3, 8'hE1}); send_byte(1'b0, 8'hE1, 1'b1);
    wait_done(1'b0, "t3 load_done");
    check("t3 frame_err sticky", 32'(frame_err_a), 1);
    check("t3 byte_count",       32'(byte_count_a), 4);

    // 4: half-bit glitch while loading -> nothing happens
    pulse_start(1'b0);
    rx_a = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    check("t4 busy",       32'(busy_a), 1);
    check("t4 byte_count", 32'(byte_count_a), 0);
    check("t4 frame_err",  32'(frame_err_a), 0);

    // 5: reset after two bytes, then a fresh load from address 0
    q_a.push_back({16'd0, 8'h12}); send_byte(1'b0, 8'h12, 1'b1);
    q_a.push_back({16'd1, 8'h34}); send_byte(1'b0, 8'h34, 1'b1);
    check("t5 count before reset", 32'(byte_count_a), 2);
    do_reset();
    load_a(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    wait_done(1'b0, "t5 load_done");
    check("t5 byte_count", 32'(byte_count_a), 4);

    // 6: full address space on dut_b, wrap on the final byte, start ignored while busy
    pulse_start(1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        pulse_start(1'b1);
        check("t6 start while busy count", 32'(byte_count_b), 8);
        check("t6 start while busy busy",  32'(busy_b), 1);
      end
      d = 8'($urandom_range(0, 255));
      q_b.push_back({4'(i), d});
      send_byte(1'b1, d, 1'b1);
    end
    wait_done(1'b1, "t6 load_done");
    check("t6 byte_count", 32'(byte_count_b), 16);
    check("t6 dram_addr",  32'(bus_b.dram_addr), 0);
    check("t6 busy",       32'(busy_b), 0);
    pulse_start(1'b1);
    check("t6 rearm load_done", 32'(load_done_b), 0);
    check("t6 rearm busy",      32'(busy_b), 1);
    check("t6 rearm count",     32'(byte_count_b), 0);

    repeat (4) @(negedge clk);
    check("pending writes a", 32'(q_a.size()), 0);
    check("pending writes b", 32'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
